// File: rtl/arm_mc_pkg.sv
// Shared types and constants for the multicycle ARM fetch path:
// FSM states, instruction field positions, PC step.
package arm_mc_pkg;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    ISSUE,
    HALT
  } fetch_state_e;

  localparam logic [31:0] PC_INC        = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  localparam int COND_HI  = 31;
  localparam int COND_LO  = 28;
  localparam int OP_HI    = 27;
  localparam int OP_LO    = 26;
  localparam int FUNCT_HI = 25;
  localparam int FUNCT_LO = 20;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 12;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus: request/address out, data/ack back.
// master = fetch unit, slave = instruction memory.
interface instr_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_regs.sv
// IR and PC registers of the fetch unit.
// Ports: clk, reset, ir_ld (load IR and step PC), pc_ld (branch load),
// ir_in, pc_in in; ir, pc out.
module fetch_regs
  import arm_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ir_ld,
  input  logic        pc_ld,
  input  logic [31:0] ir_in,
  input  logic [31:0] pc_in,
  output logic [31:0] ir,
  output logic [31:0] pc
);

  logic [31:0] ir_d, ir_q;
  logic [31:0] pc_d, pc_q;

  always_comb begin
    ir_d = ir_q;
    pc_d = pc_q;
    if (ir_ld) begin
      ir_d = ir_in;
      pc_d = pc_q + PC_INC;
    end else if (pc_ld) begin
      // branch targets are forced onto a word boundary
      pc_d = pc_in & PC_ALIGN_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q <= 32'h0;
      pc_q <= RESET_PC;
    end else begin
      ir_q <= ir_d;
      pc_q <= pc_d;
    end
  end

  assign ir = ir_q;
  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch: FETCH/WAIT/ISSUE/HALT FSM with timeout.
// Ports: clk, reset, imem (bus master), IR fields, Instr, instr_valid,
// PCPlus8, exec_done, PCSrc, Result, fetch_err (sticky).
module instr_fetch_unit
  import arm_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master imem,
  output logic [3:0]         Cond,
  output logic [1:0]         Op,
  output logic [5:0]         Funct,
  output logic [3:0]         R,
  output logic [31:0]        Instr,
  output logic               instr_valid,
  output logic [31:0]        PCPlus8,
  input  logic               exec_done,
  input  logic               PCSrc,
  input  logic [31:0]        Result,
  output logic               fetch_err
);

  localparam int CW = $clog2(IMEM_TIMEOUT + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_MAX = cnt_t'(IMEM_TIMEOUT);

  fetch_state_e state_d, state_q;
  cnt_t         cnt_d, cnt_q, cnt_inc;
  logic         err_d, err_q;
  logic         req_d, req_q;
  logic         valid_d, valid_q;
  logic         ir_ld, pc_ld;
  logic [31:0]  ir, pc;

  assign cnt_inc = cnt_q + cnt_t'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ir_ld   = 1'b0;
    pc_ld   = 1'b0;
    unique case (state_q)
      FETCH: begin
        cnt_d = '0;
        if (imem.imem_ack) begin
          ir_ld   = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem.imem_ack) begin
          ir_ld   = 1'b1;
          state_d = ISSUE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            err_d   = 1'b1;
            state_d = HALT;
          end
        end
      end
      ISSUE: begin
        if (exec_done) begin
          pc_ld   = PCSrc;
          state_d = FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = FETCH;
    endcase
    // outputs registered from the next state
    req_d   = (state_d == FETCH) || (state_d == WAIT);
    valid_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  fetch_regs #(
    .RESET_PC(RESET_PC)
  ) u_regs (
    .clk   (clk),
    .reset (reset),
    .ir_ld (ir_ld),
    .pc_ld (pc_ld),
    .ir_in (imem.imem_rdata),
    .pc_in (Result),
    .ir    (ir),
    .pc    (pc)
  );

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc;

  assign Cond  = ir[COND_HI:COND_LO];
  assign Op    = ir[OP_HI:OP_LO];
  assign Funct = ir[FUNCT_HI:FUNCT_LO];
  assign R     = ir[RD_HI:RD_LO];
  assign Instr = ir;

  assign instr_valid = valid_q;
  assign fetch_err   = err_q;

  // in ISSUE the PC already points past the instruction
  assign PCPlus8 = valid_q ? (pc + PC_INC) : (pc + PC_INC + PC_INC);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit.
// Directed scenarios plus randomized fetch/execute against a PC model.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        reset;
  logic        exec_done, PCSrc;
  logic [31:0] Result;
  logic [3:0]  Cond;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [3:0]  R;
  logic [31:0] Instr, PCPlus8;
  logic        instr_valid, fetch_err;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .IMEM_TIMEOUT(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (bus),
    .Cond        (Cond),
    .Op          (Op),
    .Funct       (Funct),
    .R           (R),
    .Instr       (Instr),
    .instr_valid (instr_valid),
    .PCPlus8     (PCPlus8),
    .exec_done   (exec_done),
    .PCSrc       (PCSrc),
    .Result      (Result),
    .fetch_err   (fetch_err)
  );

  logic        reset2;
  logic        exec_done2, PCSrc2;
  logic [31:0] Result2;
  logic [3:0]  Cond2;
  logic [1:0]  Op2;
  logic [5:0]  Funct2;
  logic [3:0]  R2;
  logic [31:0] Instr2, PCPlus8_2;
  logic        instr_valid2, fetch_err2;

  instr_fetch_unit_if bus2 ();

  instr_fetch_unit #(
    .RESET_PC(32'hFFFF_FFFC),
    .IMEM_TIMEOUT(16)
  ) dut2 (
    .clk         (clk),
    .reset       (reset2),
    .imem        (bus2),
    .Cond        (Cond2),
    .Op          (Op2),
    .Funct       (Funct2),
    .R           (R2),
    .Instr       (Instr2),
    .instr_valid (instr_valid2),
    .PCPlus8     (PCPlus8_2),
    .exec_done   (exec_done2),
    .PCSrc       (PCSrc2),
    .Result      (Result2),
    .fetch_err   (fetch_err2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.imem_ack = 1'b0;
    exec_done = 1'b0;
    PCSrc = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    exec_done = 1'b1;
    PCSrc = 1'b1;
    Result = 32'h40;
    step();
    reset = 1'b0;
    bus.imem_ack = 1'b0;
    exec_done = 1'b0;
    PCSrc = 1'b0;
    checks++;
    if ({bus.imem_req, bus.imem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_bus: req/addr/valid got %b/%h/%b want 1/00000000/0",
               bus.imem_req, bus.imem_addr, instr_valid);
    end
    checks++;
    if ({Instr, Cond, fetch_err} !== {32'h0, 4'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_ir: Instr/Cond/err got %h/%h/%b want 0/0/0",
               Instr, Cond, fetch_err);
    end
    checks++;
    if (PCPlus8 !== 32'h8) begin
      failures++;
      $display("FAIL reset_pcplus8: got %h want 00000008", PCPlus8);
    end
  endtask

  task automatic test_immediate();
    do_reset();
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hE280_1001;
    step();
    bus.imem_ack = 1'b0;
    checks++;
    if ({instr_valid, bus.imem_req} !== 2'b10) begin
      failures++;
      $display("FAIL imm_valid: valid/req got %b/%b want 1/0",
               instr_valid, bus.imem_req);
    end
    checks++;
    if ({Cond, Op, Funct, R} !== {4'hE, 2'b00, 6'b101000, 4'h1}) begin
      failures++;
      $display("FAIL imm_fields: got %h/%b/%b/%h want e/00/101000/1",
               Cond, Op, Funct, R);
    end
    checks++;
    if (PCPlus8 !== 32'h8) begin
      failures++;
      $display("FAIL imm_pcplus8: got %h want 00000008", PCPlus8);
    end
    exec_done = 1'b1;
    PCSrc = 1'b0;
    step();
    exec_done = 1'b0;
    checks++;
    if ({bus.imem_req, bus.imem_addr, instr_valid} !== {1'b1, 32'h4, 1'b0}) begin
      failures++;
      $display("FAIL imm_next: req/addr/valid got %b/%h/%b want 1/00000004/0",
               bus.imem_req, bus.imem_addr, instr_valid);
    end
  endtask

  task automatic test_wait_ack();
    logic [31:0] data;
    data = $urandom;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.imem_ack = 1'b0;
      step();
      checks++;
      if ({bus.imem_req, bus.imem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
        failures++;
        $display("FAIL wait_hold: cycle %0d req/addr/valid got %b/%h/%b want 1/0/0",
                 i, bus.imem_req, bus.imem_addr, instr_valid);
      end
    end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = data;
    step();
    bus.imem_ack = 1'b0;
    bus.imem_rdata = ~data;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({instr_valid, Instr} !== {1'b1, data}) begin
        failures++;
        $display("FAIL wait_issue: cycle %0d valid/Instr got %b/%h want 1/%h",
                 i, instr_valid, Instr, data);
      end
      step();
    end
    exec_done = 1'b1;
    PCSrc = 1'b0;
    step();
    exec_done = 1'b0;
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h4}) begin
      failures++;
      $display("FAIL wait_next: req/addr got %b/%h want 1/00000004",
               bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_branch();
    do_reset();
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hEA00_0010;
    step();
    bus.imem_ack = 1'b0;
    exec_done = 1'b1;
    PCSrc = 1'b1;
    Result = 32'h0000_0103;
    step();
    exec_done = 1'b0;
    PCSrc = 1'b0;
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0000_0100}) begin
      failures++;
      $display("FAIL branch_addr: req/addr got %b/%h want 1/00000100",
               bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_random();
    logic [31:0] pc, data, tgt;
    int          d, hold;
    logic        take;
    do_reset();
    pc = 32'h0;
    for (int t = 0; t < 40; t++) begin
      d = $urandom_range(0, 12);
      data = $urandom;
      for (int i = 0; i < d; i++) begin
        bus.imem_ack = 1'b0;
        bus.imem_rdata = $urandom;
        exec_done = 1'($urandom);
        PCSrc = 1'($urandom);
        Result = $urandom;
        step();
        checks++;
        if ({bus.imem_req, bus.imem_addr, instr_valid, fetch_err} !==
            {1'b1, pc, 1'b0, 1'b0}) begin
          failures++;
          $display("FAIL rand_wait: t%0d req/addr/valid/err got %b/%h/%b/%b want 1/%h/0/0",
                   t, bus.imem_req, bus.imem_addr, instr_valid, fetch_err, pc);
        end
      end
      bus.imem_ack = 1'b1;
      bus.imem_rdata = data;
      exec_done = 1'($urandom);
      step();
      bus.imem_ack = 1'b0;
      exec_done = 1'b0;
      checks++;
      if ({instr_valid, bus.imem_req, Instr, PCPlus8} !==
          {1'b1, 1'b0, data, pc + 32'd8}) begin
        failures++;
        $display("FAIL rand_issue: t%0d valid/req/Instr/PCPlus8 got %b/%b/%h/%h want 1/0/%h/%h",
                 t, instr_valid, bus.imem_req, Instr, PCPlus8, data, pc + 32'd8);
      end
      checks++;
      if ({Cond, Op, Funct, R} !==
          {data[31:28], data[27:26], data[25:20], data[15:12]}) begin
        failures++;
        $display("FAIL rand_fields: t%0d got %h/%b/%b/%h for IR %h",
                 t, Cond, Op, Funct, R, data);
      end
      hold = $urandom_range(0, 3);
      for (int i = 0; i < hold; i++) begin
        bus.imem_ack = 1'($urandom);
        bus.imem_rdata = $urandom;
        step();
        checks++;
        if ({instr_valid, bus.imem_req, Instr} !== {1'b1, 1'b0, data}) begin
          failures++;
          $display("FAIL rand_hold: t%0d valid/req/Instr got %b/%b/%h want 1/0/%h",
                   t, instr_valid, bus.imem_req, Instr, data);
        end
      end
      take = 1'($urandom);
      tgt = $urandom;
      if (($urandom % 4) == 0) tgt = 32'hFFFF_FFFC;
      exec_done = 1'b1;
      PCSrc = take;
      Result = tgt;
      bus.imem_ack = 1'($urandom);
      step();
      exec_done = 1'b0;
      bus.imem_ack = 1'b0;
      pc = take ? {tgt[31:2], 2'b00} : pc + 32'd4;
      checks++;
      if ({bus.imem_req, bus.imem_addr, instr_valid} !== {1'b1, pc, 1'b0}) begin
        failures++;
        $display("FAIL rand_next: t%0d req/addr/valid got %b/%h/%b want 1/%h/0",
                 t, bus.imem_req, bus.imem_addr, instr_valid, pc);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    bus.imem_ack = 1'b0;
    n = 0;
    while (fetch_err !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n != 16 && n != 17) begin
      failures++;
      $display("FAIL timeout_cycles: fetch_err after %0d cycles want 16..17", n);
    end
    checks++;
    if ({bus.imem_req, instr_valid} !== 2'b00) begin
      failures++;
      $display("FAIL timeout_halt: req/valid got %b/%b want 0/0",
               bus.imem_req, instr_valid);
    end
    for (int i = 0; i < 5; i++) begin
      bus.imem_ack = 1'b1;
      bus.imem_rdata = $urandom;
      exec_done = 1'b1;
      PCSrc = 1'b1;
      Result = $urandom;
      step();
      checks++;
      if ({fetch_err, bus.imem_req, instr_valid, Instr} !==
          {1'b1, 1'b0, 1'b0, 32'h0}) begin
        failures++;
        $display("FAIL timeout_sticky: err/req/valid/Instr got %b/%b/%b/%h want 1/0/0/0",
                 fetch_err, bus.imem_req, instr_valid, Instr);
      end
    end
    do_reset();
    checks++;
    if ({fetch_err, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h0}) begin
      failures++;
      $display("FAIL timeout_clear: err/req/addr got %b/%b/%h want 0/1/0",
               fetch_err, bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    bus.imem_ack = 1'b0;
    step();
    step();
    reset = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hA5A5_5A5A;
    step();
    reset = 1'b0;
    bus.imem_ack = 1'b0;
    checks++;
    if ({Instr, bus.imem_addr, instr_valid, bus.imem_req} !==
        {32'h0, 32'h0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL rst_wait: Instr/addr/valid/req got %h/%h/%b/%b want 0/0/0/1",
               Instr, bus.imem_addr, instr_valid, bus.imem_req);
    end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    step();
    bus.imem_ack = 1'b0;
    checks++;
    if ({instr_valid, Instr, PCPlus8} !== {1'b1, 32'h1234_5678, 32'h8}) begin
      failures++;
      $display("FAIL rst_late_ack: valid/Instr/PCPlus8 got %b/%h/%h want 1/12345678/8",
               instr_valid, Instr, PCPlus8);
    end
  endtask

  task automatic test_wrap();
    reset2 = 1'b1;
    step();
    reset2 = 1'b0;
    checks++;
    if ({bus2.imem_req, bus2.imem_addr, PCPlus8_2} !==
        {1'b1, 32'hFFFF_FFFC, 32'h4}) begin
      failures++;
      $display("FAIL wrap_reset: req/addr/PCPlus8 got %b/%h/%h want 1/fffffffc/4",
               bus2.imem_req, bus2.imem_addr, PCPlus8_2);
    end
    bus2.imem_ack = 1'b1;
    bus2.imem_rdata = 32'hE1A0_0000;
    step();
    bus2.imem_ack = 1'b0;
    checks++;
    if ({instr_valid2, PCPlus8_2} !== {1'b1, 32'h4}) begin
      failures++;
      $display("FAIL wrap_issue: valid/PCPlus8 got %b/%h want 1/00000004",
               instr_valid2, PCPlus8_2);
    end
    exec_done2 = 1'b1;
    PCSrc2 = 1'b0;
    step();
    exec_done2 = 1'b0;
    checks++;
    if ({bus2.imem_req, bus2.imem_addr} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL wrap_next: req/addr got %b/%h want 1/00000000",
               bus2.imem_req, bus2.imem_addr);
    end
  endtask

  initial begin
    reset = 1'b1;
    exec_done = 1'b0;
    PCSrc = 1'b0;
    Result = 32'h0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    reset2 = 1'b1;
    exec_done2 = 1'b0;
    PCSrc2 = 1'b0;
    Result2 = 32'h0;
    bus2.imem_ack = 1'b0;
    bus2.imem_rdata = 32'h0;
    #1;
    test_reset();
    test_immediate();
    test_wait_ack();
    test_branch();
    test_random();
    test_timeout();
    test_reset_in_wait();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: IMEM_TIMEOUT, 16, maximum cycles to wait for imem_ack before raising fetch_err.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  instruction-memory read request, held until imem_ack or timeout.
REQ-006 imem_addr  output  32  word-aligned fetch address, equal to PC while imem_req is high.
REQ-007 imem_rdata  input  32  fetched instruction word, valid when imem_ack is high.
REQ-008 imem_ack  input  1  one-cycle read completion strobe.
REQ-009 Cond  output  4  IR[31:28] to controller.
REQ-010 Op  output  2  IR[27:26] to controller.
REQ-011 Funct  output  6  IR[25:20] to controller.
REQ-012 R  output  4  IR[15:12] (Rd) to controller.
REQ-013 Instr  output  32  full instruction register.
REQ-014 instr_valid  output  1  high in ISSUE: IR fields are stable and executable.
REQ-015 PCPlus8  output  32  address of the current instruction + 8, read value of R15.
REQ-016 exec_done  input  1  controller/datapath finished the current instruction.
REQ-017 PCSrc  input  1  branch/PC write taken, sampled with exec_done.
REQ-018 Result  input  32  new PC value when PCSrc is high.
REQ-019 fetch_err  output  1  sticky: fetch timed out; cleared only by reset.

Function
REQ-020 FSM states SHALL be FETCH, WAIT, ISSUE, HALT; reset state FETCH.
REQ-021 FETCH: imem_req=1, imem_addr=PC, timeout counter cleared; next state WAIT, or ISSUE if imem_ack is already high this cycle.
REQ-022 WAIT: imem_req=1; on imem_ack latch IR<=imem_rdata, PC<=PC+4, go ISSUE; counter increments each cycle without ack.
REQ-023 Counter reaching IMEM_TIMEOUT in WAIT SHALL set fetch_err, drop imem_req, and go HALT; HALT is left only by reset.
REQ-024 ISSUE: instr_valid=1, IR held constant, imem_req=0; stays until exec_done=1.
REQ-025 On exec_done in ISSUE: PC<=Result with bits[1:0] forced to 0 if PCSrc=1, else PC unchanged; next state FETCH.
REQ-026 Latency: ack in the request cycle gives instr_valid one cycle after imem_req rises; minimum instruction period 2 cycles.
REQ-027 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-028 PCPlus8 SHALL equal PC+4 (PC already advanced) during ISSUE, modulo 2^32.
REQ-029 imem_ack outside FETCH/WAIT, and exec_done/PCSrc outside ISSUE, SHALL be ignored.
REQ-030 Fields Cond/Op/Funct/R SHALL be pure slices of IR, combinationally, in every state.

Reset
REQ-031 Reset SHALL override all inputs in the same edge: state=FETCH, PC=RESET_PC, IR=0, counter=0, fetch_err=0.
REQ-032 After reset outputs: imem_req=1, imem_addr=RESET_PC, instr_valid=0, Instr=0, PCPlus8=RESET_PC+8.
REQ-033 Reset during WAIT SHALL abandon the pending fetch; a late imem_ack after reset is treated as the ack for the new RESET_PC fetch.

Structure
REQ-034 FSM state enum, field bit positions, and PC increment constant SHALL live in a shared arm_mc_pkg package.
REQ-035 One sub-module SHALL hold IR and PC registers (fetch_regs); FSM and timeout counter stay in the top.

Verification
REQ-036 Reset, imem_ack immediate, imem_rdata=32'hE280_1001 -> instr_valid next cycle, Cond=4'hE, Op=2'b00, Funct=6'b101000, R=4'h1, PCPlus8=32'h8.
REQ-037 Ack after 3 wait cycles, exec_done after 2 ISSUE cycles, PCSrc=0 -> next imem_addr=32'h4, IR stable during ISSUE.
REQ-038 In ISSUE, exec_done=1, PCSrc=1, Result=32'h0000_0103 -> next imem_addr=32'h0000_0100.
REQ-039 RESET_PC=32'hFFFF_FFFC, one fetch, exec_done without branch -> next imem_addr=32'h0, PCPlus8=32'h4 during first ISSUE.
REQ-040 No imem_ack for 16 cycles -> fetch_err=1, imem_req=0, state HALT; further acks and exec_done ignored until reset.
REQ-041 Reset asserted in WAIT with ack in the same cycle -> IR stays 0, imem_addr=RESET_PC, instr_valid=0 next cycle.
